// File: rtl/mc_trip_monitor_pkg.sv
// rtl/mc_trip_monitor_pkg.sv - shared state, error codes and helpers for the trip monitor
package mc_trip_monitor_pkg;

  typedef enum logic [1:0] {RUN, DONE, ERROR} state_t;

  localparam logic [2:0] ERR_NONE     = 3'd0;
  localparam logic [2:0] ERR_OVERLOAD = 3'd1;
  localparam logic [2:0] ERR_DIR      = 3'd2;
  localparam logic [2:0] ERR_UNSAFE   = 3'd3;
  localparam logic [2:0] ERR_STALL    = 3'd4;
  localparam logic [2:0] ERR_FINISH   = 3'd5;
  localparam logic [2:0] ERR_RESTART  = 3'd6;

  localparam logic [1:0] START_M = 2'd3;
  localparam logic [1:0] START_C = 2'd3;

  // Widened to 3 bits so two differences can be summed without overflow.
  function automatic logic [2:0] abs_diff(input logic [1:0] a, input logic [1:0] b);
    return (a >= b) ? {1'b0, a - b} : {1'b0, b - a};
  endfunction

endpackage

// File: rtl/mc_bank_safe.sv
// rtl/mc_bank_safe.sv - combinational safety check of one river bank
module mc_bank_safe (
  input  logic [1:0] m,
  input  logic [1:0] c,
  output logic       safe
);

  assign safe = (m == 2'd0) || (c <= m);

endmodule

// File: rtl/mc_trip_monitor.sv
// rtl/mc_trip_monitor.sv - checks solver output trip by trip, counts trips and solutions
module mc_trip_monitor
  import mc_trip_monitor_pkg::*;
#(
  parameter int TRIP_W    = 5,
  parameter int SOLVE_W   = 4,
  parameter int STALL_MAX = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         missionary_next,
  input  logic [1:0]         cannibal_next,
  input  logic               finish,
  output logic               trip_valid,
  output logic [1:0]         load_m,
  output logic [1:0]         load_c,
  output logic               boat_side,
  output logic [TRIP_W-1:0]  trip_count,
  output logic [SOLVE_W-1:0] solve_count,
  output logic               done,
  output logic               error,
  output logic [2:0]         err_code
);

  localparam int STALL_W = $clog2(STALL_MAX + 1);

  state_t             state;
  logic [1:0]         prev_m;
  logic [1:0]         prev_c;
  logic [STALL_W-1:0] stall_cnt;

  logic [2:0] dm;
  logic [2:0] dc;
  logic [2:0] load;
  logic [1:0] far_m;
  logic [1:0] far_c;
  logic       near_safe;
  logic       far_safe;
  logic       wrong_dir;
  logic       at_zero;
  logic       at_start;
  logic [2:0] check_code;

  assign dm    = abs_diff(missionary_next, prev_m);
  assign dc    = abs_diff(cannibal_next, prev_c);
  assign load  = dm + dc;
  assign far_m = START_M - missionary_next;
  assign far_c = START_C - cannibal_next;

  assign at_zero  = (missionary_next == 2'd0) && (cannibal_next == 2'd0);
  assign at_start = (missionary_next == START_M) && (cannibal_next == START_C);

  // Boat on start bank can only take people away from it, and vice versa.
  assign wrong_dir = boat_side ? ((missionary_next < prev_m) || (cannibal_next < prev_c))
                               : ((missionary_next > prev_m) || (cannibal_next > prev_c));

  mc_bank_safe u_near (.m(missionary_next), .c(cannibal_next), .safe(near_safe));
  mc_bank_safe u_far  (.m(far_m),           .c(far_c),         .safe(far_safe));

  always_comb begin
    check_code = ERR_NONE;
    if (load > 3'd2)
      check_code = ERR_OVERLOAD;
    else if (wrong_dir)
      check_code = ERR_DIR;
    else if (!(near_safe && far_safe))
      check_code = ERR_UNSAFE;
    else if (finish != at_zero)
      check_code = ERR_FINISH;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= RUN;
      prev_m      <= START_M;
      prev_c      <= START_C;
      stall_cnt   <= '0;
      trip_valid  <= 1'b0;
      load_m      <= 2'd0;
      load_c      <= 2'd0;
      boat_side   <= 1'b0;
      trip_count  <= '0;
      solve_count <= '0;
      done        <= 1'b0;
      error       <= 1'b0;
      err_code    <= ERR_NONE;
    end else begin
      trip_valid <= 1'b0;
      case (state)
        RUN: begin
          if (load == 3'd0) begin
            if (stall_cnt == STALL_W'(STALL_MAX - 1)) begin
              state    <= ERROR;
              error    <= 1'b1;
              err_code <= ERR_STALL;
            end else begin
              stall_cnt <= stall_cnt + STALL_W'(1);
            end
          end else if (check_code != ERR_NONE) begin
            state    <= ERROR;
            error    <= 1'b1;
            err_code <= check_code;
          end else begin
            trip_valid <= 1'b1;
            load_m     <= dm[1:0];
            load_c     <= dc[1:0];
            boat_side  <= ~boat_side;
            prev_m     <= missionary_next;
            prev_c     <= cannibal_next;
            stall_cnt  <= '0;
            if (trip_count != '1)
              trip_count <= trip_count + TRIP_W'(1);
            // A legal trip to 0/0 already implies finish was asserted.
            if (at_zero) begin
              state       <= DONE;
              done        <= 1'b1;
              solve_count <= solve_count + SOLVE_W'(1);
            end
          end
        end
        DONE: begin
          if (at_start) begin
            state      <= RUN;
            done       <= 1'b0;
            trip_count <= '0;
            boat_side  <= 1'b0;
            prev_m     <= START_M;
            prev_c     <= START_C;
            stall_cnt  <= '0;
          end else if (!at_zero) begin
            state    <= ERROR;
            done     <= 1'b0;
            error    <= 1'b1;
            err_code <= ERR_RESTART;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_trip_monitor.sv
// tb/tb_mc_trip_monitor.sv - scoreboard bench for mc_trip_monitor
module tb_mc_trip_monitor;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] missionary_next;
  logic [1:0] cannibal_next;
  logic       finish;
  logic       trip_valid;
  logic [1:0] load_m;
  logic [1:0] load_c;
  logic       boat_side;
  logic [4:0] trip_count;
  logic [3:0] solve_count;
  logic       done;
  logic       error;
  logic [2:0] err_code;

  mc_trip_monitor #(.TRIP_W(5), .SOLVE_W(4), .STALL_MAX(4)) dut (
    .clk(clk), .reset(reset),
    .missionary_next(missionary_next), .cannibal_next(cannibal_next), .finish(finish),
    .trip_valid(trip_valid), .load_m(load_m), .load_c(load_c), .boat_side(boat_side),
    .trip_count(trip_count), .solve_count(solve_count), .done(done),
    .error(error), .err_code(err_code)
  );

  always #5 clk = ~clk;

  typedef struct {
    int tv, lm, lc, side, tc, sc, dn, er, code;
  } exp_t;

  exp_t q[$];
  int vectors = 0;
  int misses  = 0;
  int tv_seen = 0;

  // Reference model state: st 0=RUN 1=DONE 2=ERROR
  int st, pm, pc, side, tc, sc, stall, lm, lc, tv, dn, er, code;

  int opt_seq[12] = '{33, 31, 32, 30, 31, 11, 22, 2, 3, 1, 2, 0};

  task automatic check(input string tag, input int actual, input int expected);
    vectors++;
    if (actual !== expected) begin
      misses++;
      $display("FAIL %s: got %0d, want %0d", tag, actual, expected);
    end
  endtask

  function automatic bit unsafe(input int m, input int c);
    return (m > 0) && (c > m);
  endfunction

  task automatic model_reset();
    st = 0; pm = 3; pc = 3; side = 0; tc = 0; sc = 0; stall = 0;
    lm = 0; lc = 0; tv = 0; dn = 0; er = 0; code = 0;
  endtask

  task automatic model_fail(input int c);
    st = 2; er = 1; dn = 0; code = c;
  endtask

  task automatic model_step(input int m, input int c, input bit f);
    int dmm, dcc, ld;
    bit zero;
    tv = 0;
    zero = (m == 0) && (c == 0);
    dmm = (m > pm) ? m - pm : pm - m;
    dcc = (c > pc) ? c - pc : pc - c;
    ld = dmm + dcc;
    if (st == 0) begin
      if (ld == 0) begin
        stall++;
        if (stall >= 4) model_fail(4);
      end else if (ld > 2) model_fail(1);
      else if ((side == 0 && (m > pm || c > pc)) || (side == 1 && (m < pm || c < pc))) model_fail(2);
      else if (unsafe(m, c) || unsafe(3 - m, 3 - c)) model_fail(3);
      else if (f != zero) model_fail(5);
      else begin
        tv = 1; lm = dmm; lc = dcc; side = 1 - side;
        if (tc < 31) tc++;
        pm = m; pc = c; stall = 0;
        if (zero) begin
          st = 1; dn = 1; sc = (sc + 1) % 16;
        end
      end
    end else if (st == 1) begin
      if (m == 3 && c == 3) begin
        st = 0; dn = 0; tc = 0; side = 0; pm = 3; pc = 3; stall = 0;
      end else if (!zero) model_fail(6);
    end
  endtask

  function automatic exp_t snapshot();
    exp_t e;
    e.tv = tv; e.lm = lm; e.lc = lc; e.side = side; e.tc = tc;
    e.sc = sc; e.dn = dn; e.er = er; e.code = code;
    return e;
  endfunction

  task automatic check_outputs(input string tag, input exp_t e);
    check({tag, ".trip_valid"},  int'(trip_valid),  e.tv);
    check({tag, ".load_m"},      int'(load_m),      e.lm);
    check({tag, ".load_c"},      int'(load_c),      e.lc);
    check({tag, ".boat_side"},   int'(boat_side),   e.side);
    check({tag, ".trip_count"},  int'(trip_count),  e.tc);
    check({tag, ".solve_count"}, int'(solve_count), e.sc);
    check({tag, ".done"},        int'(done),        e.dn);
    check({tag, ".error"},       int'(error),       e.er);
    check({tag, ".err_code"},    int'(err_code),    e.code);
  endtask

  task automatic apply(input string tag, input int v, input bit f);
    exp_t e;
    missionary_next = 2'(v / 10);
    cannibal_next   = 2'(v % 10);
    finish          = f;
    model_step(v / 10, v % 10, f);
    q.push_back(snapshot());
    @(posedge clk);
    #1;
    if (q.size() == 0) begin
      check({tag, ".sb_empty"}, 1, 0);
    end else begin
      e = q.pop_front();
      if (trip_valid) tv_seen++;
      check_outputs($sformatf("%s@%0d", tag, v), e);
    end
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    q.delete();
    check_outputs({tag, ".reset"}, snapshot());
    @(negedge clk);
    reset = 1'b0;
    tv_seen = 0;
  endtask

  task automatic run_opt(input string tag);
    for (int i = 0; i < 12; i++) begin
      apply(tag, opt_seq[i], opt_seq[i] == 0);
      if (i == 5) begin
        check({tag, ".trip5_load_m"}, int'(load_m), 2);
        check({tag, ".trip5_load_c"}, int'(load_c), 0);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    missionary_next = 2'd3;
    cannibal_next = 2'd3;
    finish = 1'b0;
    model_reset();
    #1;
    check_outputs("init", snapshot());
    @(negedge clk);
    reset = 1'b0;

    run_opt("opt1");
    check("opt1.pulses", tv_seen, 11);
    check("opt1.trip_count", int'(trip_count), 11);
    check("opt1.done", int'(done), 1);
    check("opt1.solve_count", int'(solve_count), 1);
    check("opt1.error", int'(error), 0);

    apply("idle", 0, 1'b1);
    apply("idle", 0, 1'b1);
    check("idle.done", int'(done), 1);
    apply("restart", 33, 1'b0);
    check("restart.trip_count", int'(trip_count), 0);
    check("restart.boat_side", int'(boat_side), 0);
    check("restart.done", int'(done), 0);
    run_opt("opt2");
    check("opt2.solve_count", int'(solve_count), 2);

    do_reset("unsafe");
    apply("unsafe", 33, 1'b0);
    apply("unsafe", 31, 1'b0);
    apply("unsafe", 32, 1'b0);
    apply("unsafe", 21, 1'b0);
    apply("unsafe", 11, 1'b0);
    check("unsafe.err_code", int'(err_code), 3);
    check("unsafe.trip_count", int'(trip_count), 2);

    do_reset("overload");
    apply("overload", 33, 1'b0);
    apply("overload", 11, 1'b0);
    check("overload.err_code", int'(err_code), 1);

    do_reset("dir");
    apply("dir", 33, 1'b0);
    apply("dir", 32, 1'b0);
    apply("dir", 31, 1'b0);
    check("dir.err_code", int'(err_code), 2);
    check("dir.trip_count", int'(trip_count), 1);

    do_reset("stall");
    for (int i = 0; i < 4; i++) apply("stall", 33, 1'b0);
    check("stall.err_code", int'(err_code), 4);

    do_reset("finish");
    apply("finish", 33, 1'b0);
    apply("finish", 31, 1'b1);
    check("finish.err_code", int'(err_code), 5);

    do_reset("badrestart");
    run_opt("badrestart");
    apply("badrestart", 12, 1'b0);
    check("badrestart.err_code", int'(err_code), 6);
    check("badrestart.done", int'(done), 0);

    do_reset("midreset");
    for (int i = 0; i < 7; i++) apply("midreset", opt_seq[i], 1'b0);
    check("midreset.trip_count", int'(trip_count), 6);
    do_reset("midreset");
    run_opt("again");
    check("again.done", int'(done), 1);
    check("again.solve_count", int'(solve_count), 1);
    check("again.trip_count", int'(trip_count), 11);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
    $finish;
  end

endmodule
